// File: rtl/uart_cipher_fifo.sv
// Buffered byte stage between uart_rx and uart_tx. Queues received bytes, optionally XORs
// them with an 8-bit Galois LFSR keystream, and launches each one with a busy-tracked handshake.
module uart_cipher_fifo #(
    parameter int         DEPTH       = 16,
    parameter logic [7:0] SEED        = 8'hA5,
    parameter int         ACK_TIMEOUT = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           rx_data_valid,
    input  logic [7:0]                     rx_data,
    input  logic                           tx_busy,
    output logic                           tx_start,
    output logic [7:0]                     tx_data,
    input  logic                           cipher_en,
    input  logic                           key_load,
    input  logic [7:0]                     key,
    input  logic                           clr_ovf,
    output logic [$clog2(DEPTH+1)-1:0]     fifo_count,
    output logic                           overflow
);

    localparam int         AW        = $clog2(DEPTH);
    localparam int         CW        = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [7:0] ACK_MAX   = 8'(ACK_TIMEOUT);
    // An all-zero state would lock the LFSR, so zero seeds and keys become 8'h01.
    localparam logic [7:0] SEED_EFF  = (SEED == 8'h00) ? 8'h01 : SEED;

    typedef enum logic [1:0] {IDLE, WAIT_HI, WAIT_LO} state_t;

    state_t      state;
    logic [7:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [7:0]  lfsr;
    logic [7:0]  wait_cnt;
    logic        full;
    logic        push;
    logic        launch;
    logic [7:0]  head;

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {1'b0, s[7:1]} ^ (s[0] ? 8'hB8 : 8'h00);
    endfunction

    assign full   = (fifo_count == FULL_CNT);
    assign push   = rx_data_valid && !full;
    assign launch = (state == IDLE) && (fifo_count != '0) && !tx_busy;
    assign head   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= rx_data;
        end
    end

    // A full FIFO drops the incoming byte even when a pop frees a slot in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (launch) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, launch})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
            if (rx_data_valid && full) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= SEED_EFF;
        end else if (key_load) begin
            lfsr <= (key == 8'h00) ? 8'h01 : key;
        end else if (launch && cipher_en) begin
            lfsr <= lfsr_step(lfsr);
        end
    end

    // WAIT_HI gives up after ACK_TIMEOUT idle cycles so a silent transmitter cannot stall the queue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
            wait_cnt <= 8'h00;
        end else begin
            tx_start <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (launch) begin
                        tx_data  <= head ^ (cipher_en ? lfsr : 8'h00);
                        tx_start <= 1'b1;
                        wait_cnt <= 8'h00;
                        state    <= WAIT_HI;
                    end
                end
                WAIT_HI: begin
                    if (tx_busy) begin
                        state <= WAIT_LO;
                    end else if (wait_cnt == ACK_MAX) begin
                        state <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                WAIT_LO: begin
                    if (!tx_busy) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cipher_fifo.sv
// Self-checking bench for uart_cipher_fifo: scenario tasks against a queue-based model
// of the FIFO and keystream; a second instance decrypts the first one's output.
module tb_uart_cipher_fifo;

    localparam int DEPTH       = 16;
    localparam int ACK_TIMEOUT = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_data_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       cipher_en = 1'b0;
    logic       key_load = 1'b0;
    logic [7:0] key = 8'h00;
    logic       clr_ovf = 1'b0;
    logic       busy_man = 1'b0;
    logic       busy_auto = 1'b0;
    logic       auto_mode = 1'b0;
    logic       tx_busy;
    logic       tx_start;
    logic [7:0] tx_data;
    logic [4:0] fifo_count;
    logic       overflow;
    logic       start2;
    logic [7:0] data2;
    logic [4:0] count2;
    logic       ovf2;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [7:0] out_q[$];
    int         out_cyc[$];
    logic [7:0] out2_q[$];

    assign tx_busy = auto_mode ? busy_auto : busy_man;

    uart_cipher_fifo #(.DEPTH(DEPTH), .SEED(8'hA5), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data_valid(rx_data_valid), .rx_data(rx_data),
        .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data), .cipher_en(cipher_en),
        .key_load(key_load), .key(key), .clr_ovf(clr_ovf), .fifo_count(fifo_count),
        .overflow(overflow)
    );

    // Same seed, fed by the first instance: decrypts its ciphertext back to plaintext.
    uart_cipher_fifo #(.DEPTH(DEPTH), .SEED(8'hA5), .ACK_TIMEOUT(ACK_TIMEOUT)) dut2 (
        .clk(clk), .rst_n(rst_n), .rx_data_valid(tx_start), .rx_data(tx_data),
        .tx_busy(1'b0), .tx_start(start2), .tx_data(data2), .cipher_en(cipher_en),
        .key_load(1'b0), .key(8'h00), .clr_ovf(1'b0), .fifo_count(count2),
        .overflow(ovf2)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tx_start) begin
            out_q.push_back(tx_data);
            out_cyc.push_back(cyc);
        end
        if (start2) begin
            out2_q.push_back(data2);
        end
    end

    // Behaves like uart_tx: raises busy shortly after each launch, for a few cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (tx_start) begin
                repeat ($urandom_range(0, 1)) @(negedge clk);
                busy_auto = 1'b1;
                repeat ($urandom_range(1, 4)) @(negedge clk);
                busy_auto = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {1'b0, s[7:1]} ^ (s[0] ? 8'hB8 : 8'h00);
    endfunction

    task automatic clear_queues();
        out_q.delete();
        out_cyc.delete();
        out2_q.delete();
    endtask

    task automatic push_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data       = b;
        rx_data_valid = 1'b1;
        @(negedge clk);
        rx_data_valid = 1'b0;
    endtask

    task automatic wait_outputs(input int n, input int bound);
        int t = 0;
        while (out_q.size() < n && t < bound) begin
            @(negedge clk);
            t++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++; if (tx_start !== 1'b0) begin errors++; $display("[TB] FAIL reset_tx_start got %b want 0", tx_start); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_tx_data got %h want 00", tx_data); end
        checks++; if (fifo_count !== 5'd0) begin errors++; $display("[TB] FAIL reset_count got %0d want 0", fifo_count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow got %b want 0", overflow); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_pass_through();
        clear_queues();
        cipher_en = 1'b0;
        auto_mode = 1'b0;
        busy_man  = 1'b0;
        @(negedge clk);
        rx_data       = 8'h41;
        rx_data_valid = 1'b1;
        @(negedge clk);
        rx_data_valid = 1'b0;
        checks++; if (fifo_count !== 5'd1) begin errors++; $display("[TB] FAIL pt_count_cycle1 got %0d want 1", fifo_count); end
        checks++; if (tx_start !== 1'b0) begin errors++; $display("[TB] FAIL pt_early_start got %b want 0", tx_start); end
        @(negedge clk);
        checks++; if (tx_start !== 1'b1) begin errors++; $display("[TB] FAIL pt_start_cycle2 got %b want 1", tx_start); end
        checks++; if (tx_data !== 8'h41) begin errors++; $display("[TB] FAIL pt_data got %h want 41", tx_data); end
        checks++; if (fifo_count !== 5'd0) begin errors++; $display("[TB] FAIL pt_count_cycle2 got %0d want 0", fifo_count); end
        repeat ($urandom_range(2, 10) - 1) @(negedge clk);
        busy_man = 1'b1;
        repeat (2) @(negedge clk);
        busy_man = 1'b0;
        repeat (12) @(negedge clk);
        checks++; if (out_q.size() != 1) begin errors++; $display("[TB] FAIL pt_launch_count got %0d want 1", out_q.size()); end
        checks++; if (tx_data !== 8'h41) begin errors++; $display("[TB] FAIL pt_data_hold got %h want 41", tx_data); end
    endtask

    // Plaintext and the keystream-derived ciphertext come from the model; the second
    // instance must reproduce the plaintext.
    task automatic test_cipher();
        logic [7:0] model_lfsr = 8'hA5;
        logic [7:0] plain[$];
        logic [7:0] expct[$];
        logic [7:0] b;
        repeat (10) @(negedge clk);
        clear_queues();
        cipher_en = 1'b1;
        auto_mode = 1'b1;
        for (int i = 0; i < 8; i++) begin
            b = (i < 2) ? 8'h00 : 8'($urandom);
            plain.push_back(b);
            expct.push_back(b ^ model_lfsr);
            model_lfsr = lfsr_step(model_lfsr);
            push_byte(b);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        begin
            int t = 0;
            while ((out_q.size() < 8 || out2_q.size() < 8) && t < 600) begin
                @(negedge clk);
                t++;
            end
        end
        checks++; if (out_q.size() != 8) begin errors++; $display("[TB] FAIL cipher_count got %0d want 8", out_q.size()); end
        checks++; if (out2_q.size() != 8) begin errors++; $display("[TB] FAIL decrypt_count got %0d want 8", out2_q.size()); end
        checks++; if (expct[0] !== 8'hA5 || expct[1] !== 8'hEA) begin errors++; $display("[TB] FAIL model_keystream got %h %h want a5 ea", expct[0], expct[1]); end
        for (int i = 0; i < 8; i++) begin
            if (i < out_q.size()) begin
                checks++; if (out_q[i] !== expct[i]) begin errors++; $display("[TB] FAIL cipher_byte%0d got %h want %h", i, out_q[i], expct[i]); end
            end
            if (i < out2_q.size()) begin
                checks++; if (out2_q[i] !== plain[i]) begin errors++; $display("[TB] FAIL decrypt_byte%0d got %h want %h", i, out2_q[i], plain[i]); end
            end
        end
        repeat (12) @(negedge clk);
    endtask

    task automatic test_overflow();
        cipher_en = 1'b0;
        auto_mode = 1'b0;
        busy_man  = 1'b1;
        repeat (40) @(negedge clk);
        clear_queues();
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            if (i == 16) begin
                checks++; if (fifo_count !== 5'd16) begin errors++; $display("[TB] FAIL ovf_full_count got %0d want 16", fifo_count); end
                checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf_early got %b want 0", overflow); end
            end
            rx_data       = 8'(i);
            rx_data_valid = 1'b1;
        end
        @(negedge clk);
        rx_data_valid = 1'b0;
        checks++; if (fifo_count !== 5'd16) begin errors++; $display("[TB] FAIL ovf_count got %0d want 16", fifo_count); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_set got %b want 1", overflow); end
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf_clear got %b want 0", overflow); end
        // Drop and pop in the same cycle: the byte is still lost.
        rx_data       = 8'h77;
        rx_data_valid = 1'b1;
        busy_man      = 1'b0;
        @(negedge clk);
        rx_data_valid = 1'b0;
        auto_mode     = 1'b1;
        checks++; if (tx_start !== 1'b1) begin errors++; $display("[TB] FAIL ovf_pop_start got %b want 1", tx_start); end
        checks++; if (fifo_count !== 5'd15) begin errors++; $display("[TB] FAIL ovf_pop_count got %0d want 15", fifo_count); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_pop_set got %b want 1", overflow); end
        wait_outputs(16, 800);
        repeat (12) @(negedge clk);
        checks++; if (out_q.size() != 16) begin errors++; $display("[TB] FAIL ovf_drain_count got %0d want 16", out_q.size()); end
        for (int i = 0; i < 16; i++) begin
            if (i < out_q.size()) begin
                checks++; if (out_q[i] !== 8'(i)) begin errors++; $display("[TB] FAIL ovf_order%0d got %h want %h", i, out_q[i], 8'(i)); end
            end
        end
        checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_sticky got %b want 1", overflow); end
        @(negedge clk);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf_final_clear got %b want 0", overflow); end
    endtask

    task automatic test_timeout();
        logic [7:0] a;
        logic [7:0] b;
        a = 8'($urandom);
        b = 8'($urandom);
        auto_mode = 1'b0;
        busy_man  = 1'b0;
        cipher_en = 1'b0;
        repeat (20) @(negedge clk);
        clear_queues();
        @(negedge clk);
        rx_data       = a;
        rx_data_valid = 1'b1;
        @(negedge clk);
        rx_data       = b;
        @(negedge clk);
        rx_data_valid = 1'b0;
        wait_outputs(2, 100);
        checks++; if (out_q.size() != 2) begin errors++; $display("[TB] FAIL to_count got %0d want 2", out_q.size()); end
        if (out_q.size() == 2) begin
            checks++; if (out_q[0] !== a || out_q[1] !== b) begin errors++; $display("[TB] FAIL to_data got %h %h want %h %h", out_q[0], out_q[1], a, b); end
            checks++; if (out_cyc[1] - out_cyc[0] != ACK_TIMEOUT + 2) begin errors++; $display("[TB] FAIL to_spacing got %0d want %0d", out_cyc[1] - out_cyc[0], ACK_TIMEOUT + 2); end
        end
        repeat (10) @(negedge clk);
    endtask

    task automatic test_key_load();
        logic [7:0] c1;
        logic [7:0] c2;
        logic [7:0] k;
        logic [7:0] model_lfsr;
        c1 = 8'($urandom);
        c2 = 8'($urandom);
        k  = 8'($urandom_range(1, 255));
        auto_mode = 1'b1;
        cipher_en = 1'b1;
        repeat (12) @(negedge clk);
        clear_queues();
        @(negedge clk);
        key_load = 1'b1;
        key      = 8'h00;
        @(negedge clk);
        key_load = 1'b0;
        model_lfsr = 8'h01;
        push_byte(8'hFF);
        wait_outputs(1, 50);
        checks++; if (out_q.size() != 1 || out_q[0] !== 8'hFE) begin errors++; $display("[TB] FAIL key_zero got %h want fe", (out_q.size() > 0) ? out_q[0] : 8'hXX); end
        model_lfsr = lfsr_step(model_lfsr);
        repeat (12) @(negedge clk);
        // Load lands on the same edge as the launch of c1.
        @(negedge clk);
        rx_data       = c1;
        rx_data_valid = 1'b1;
        @(negedge clk);
        rx_data_valid = 1'b0;
        key_load      = 1'b1;
        key           = k;
        @(negedge clk);
        key_load = 1'b0;
        checks++; if (tx_start !== 1'b1) begin errors++; $display("[TB] FAIL key_coincide_start got %b want 1", tx_start); end
        checks++; if (tx_data !== (c1 ^ model_lfsr)) begin errors++; $display("[TB] FAIL key_coincide_data got %h want %h", tx_data, c1 ^ model_lfsr); end
        repeat (12) @(negedge clk);
        push_byte(c2);
        wait_outputs(3, 50);
        checks++; if (out_q.size() != 3 || out_q[2] !== (c2 ^ k)) begin errors++; $display("[TB] FAIL key_after_load got %h want %h", (out_q.size() > 2) ? out_q[2] : 8'hXX, c2 ^ k); end
        repeat (12) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        auto_mode = 1'b0;
        busy_man  = 1'b0;
        cipher_en = 1'b0;
        repeat (12) @(negedge clk);
        clear_queues();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            rx_data       = 8'h11 + 8'(i);
            rx_data_valid = 1'b1;
            if (i == 2) busy_man = 1'b1;
        end
        @(negedge clk);
        rx_data_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (fifo_count !== 5'd5) begin errors++; $display("[TB] FAIL mid_queued got %0d want 5", fifo_count); end
        checks++; if (out_q.size() != 1) begin errors++; $display("[TB] FAIL mid_launched got %0d want 1", out_q.size()); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (tx_start !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_start got %b want 0", tx_start); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("[TB] FAIL mid_rst_data got %h want 00", tx_data); end
        checks++; if (fifo_count !== 5'd0) begin errors++; $display("[TB] FAIL mid_rst_count got %0d want 0", fifo_count); end
        @(negedge clk);
        rst_n    = 1'b1;
        busy_man = 1'b0;
        repeat (20) @(negedge clk);
        checks++; if (out_q.size() != 1) begin errors++; $display("[TB] FAIL mid_no_launch got %0d want 1", out_q.size()); end
        cipher_en = 1'b1;
        push_byte(8'h00);
        wait_outputs(2, 50);
        checks++; if (out_q.size() != 2 || out_q[1] !== 8'hA5) begin errors++; $display("[TB] FAIL mid_seed_restored got %h want a5", (out_q.size() > 1) ? out_q[1] : 8'hXX); end
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_cipher();
        test_overflow();
        test_timeout();
        test_key_load();
        test_reset_mid();
        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
